// File: rtl/register_file_mp_pkg.sv
// Shared defaults for the multi-port register file.
// Widths, port counts and the zero-register / bypass mode switches.
package register_file_mp_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NREAD  = 2;
  localparam int DEF_NWRITE = 2;

  localparam int MODE_OFF = 0;
  localparam int MODE_ON  = 1;

endpackage

// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: read, write, reserve and status.
// Ports are flattened with port k at [k*W +: W].
interface register_file_mp_if
  import register_file_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREAD  = DEF_NREAD,
  parameter int NWRITE = DEF_NWRITE
);

  logic [NREAD*ADDR_W-1:0]  rd_addr;
  logic [NREAD*DATA_W-1:0]  rd_data;
  logic [NREAD-1:0]         rd_busy;
  logic [NWRITE-1:0]        wr_en;
  logic [NWRITE*ADDR_W-1:0] wr_addr;
  logic [NWRITE*DATA_W-1:0] wr_data;
  logic                     resv_en;
  logic [ADDR_W-1:0]        resv_addr;
  logic                     wr_conflict;
  logic [ADDR_W:0]          busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data,
    output resv_en, resv_addr,
    input  rd_data, rd_busy, wr_conflict, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data,
    input  resv_en, resv_addr,
    output rd_data, rd_busy, wr_conflict, busy_cnt
  );

endinterface

// File: rtl/register_file_mp_read_port.sv
// One combinational read port: array mux, write bypass, busy mask.
// Later write ports override earlier ones on an address match.
module rf_read_port
  import register_file_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NWRITE   = DEF_NWRITE,
  parameter int ZERO_REG = MODE_ON,
  parameter int BYPASS   = MODE_ON
) (
  input  logic                               rst,
  input  logic [ADDR_W-1:0]                  addr,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]   mem,
  input  logic [2**ADDR_W-1:0]               busy_vec,
  input  logic [NWRITE-1:0]                  wr_en,
  input  logic [NWRITE*ADDR_W-1:0]           wr_addr,
  input  logic [NWRITE*DATA_W-1:0]           wr_data,
  output logic [DATA_W-1:0]                  data,
  output logic                               busy
);

  always_comb begin
    data = mem[addr];
    busy = busy_vec[addr];
    if (BYPASS != 0) begin
      for (int w = 0; w < NWRITE; w++) begin
        if (wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] == addr) begin
          data = wr_data[w*DATA_W +: DATA_W];
          busy = 1'b0;
        end
      end
    end
    if (ZERO_REG != 0 && addr == '0) begin
      data = '0;
      busy = 1'b0;
    end
    if (!rst) begin
      data = '0;
      busy = 1'b0;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with bypass, busy scoreboard,
// write-conflict flag and registered busy count.
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NREAD    = DEF_NREAD,
  parameter int NWRITE   = DEF_NWRITE,
  parameter int ZERO_REG = MODE_ON,
  parameter int BYPASS   = MODE_ON
) (
  input logic               clk,
  input logic               rst,
  register_file_mp_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DEPTH-1:0]             busy;
  logic [DEPTH-1:0]             busy_nxt;
  logic [ADDR_W:0]              cnt_nxt;
  logic                         conflict_nxt;
  logic                         conflict_q;
  logic [ADDR_W:0]              cnt_q;

  always_comb begin
    busy_nxt = busy;
    for (int w = 0; w < NWRITE; w++) begin
      if (bus.wr_en[w])
        busy_nxt[bus.wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
    end
    // A new reservation beats a retiring write to the same register
    if (bus.resv_en &&
        !(ZERO_REG != 0 && bus.resv_addr == '0))
      busy_nxt[bus.resv_addr] = 1'b1;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
  end

  always_comb begin
    conflict_nxt = 1'b0;
    for (int i = 0; i < NWRITE; i++) begin
      for (int j = i + 1; j < NWRITE; j++) begin
        if (bus.wr_en[i] && bus.wr_en[j] &&
            bus.wr_addr[i*ADDR_W +: ADDR_W] ==
            bus.wr_addr[j*ADDR_W +: ADDR_W])
          conflict_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem        <= '0;
      busy       <= '0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      for (int w = 0; w < NWRITE; w++) begin
        if (bus.wr_en[w] &&
            !(ZERO_REG != 0 &&
              bus.wr_addr[w*ADDR_W +: ADDR_W] == '0))
          mem[bus.wr_addr[w*ADDR_W +: ADDR_W]] <=
            bus.wr_data[w*DATA_W +: DATA_W];
      end
      busy       <= busy_nxt;
      conflict_q <= conflict_nxt;
      cnt_q      <= cnt_nxt;
    end
  end

  assign bus.wr_conflict = conflict_q;
  assign bus.busy_cnt    = cnt_q;

  for (genvar r = 0; r < NREAD; r++) begin : g_rd
    rf_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NWRITE  (NWRITE),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_rd (
      .rst     (rst),
      .addr    (bus.rd_addr[r*ADDR_W +: ADDR_W]),
      .mem     (mem),
      .busy_vec(busy),
      .wr_en   (bus.wr_en),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .data    (bus.rd_data[r*DATA_W +: DATA_W]),
      .busy    (bus.rd_busy[r])
    );
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench: bypassing DUT a and non-bypassing DUT b share stimulus.
module tb_register_file_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  register_file_mp_if a ();
  register_file_mp_if b ();

  assign b.rd_addr   = a.rd_addr;
  assign b.wr_en     = a.wr_en;
  assign b.wr_addr   = a.wr_addr;
  assign b.wr_data   = a.wr_data;
  assign b.resv_en   = a.resv_en;
  assign b.resv_addr = a.resv_addr;

  register_file_mp #(.BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .bus(a)
  );
  register_file_mp #(.BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .bus(b)
  );

  task automatic idle();
    a.wr_en   = '0;
    a.resv_en = 1'b0;
  endtask

  task automatic test_reset();
    a.rd_addr   = {5'd3, 5'd1};
    a.wr_en     = '0;
    a.wr_addr   = '0;
    a.wr_data   = '0;
    a.resv_en   = 1'b0;
    a.resv_addr = '0;
    #2 rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    tests++;
    if (a.rd_data !== 64'd0) begin
      fails++;
      $display("FAIL reset_rd got %0h want 0", a.rd_data);
    end
    tests++;
    if (a.busy_cnt !== 6'd0) begin
      fails++;
      $display("FAIL reset_cnt got %0d want 0", a.busy_cnt);
    end
    tests++;
    if (a.wr_conflict !== 1'b0) begin
      fails++;
      $display("FAIL reset_conf got %0b want 0", a.wr_conflict);
    end
  endtask

  task automatic test_write();
    @(negedge clk);
    a.wr_en   = 2'b01;
    a.wr_addr = {5'd0, 5'd21};
    a.wr_data = {32'd0, 32'd45};
    @(negedge clk);
    idle();
    a.rd_addr = {5'd5, 5'd21};
    #1;
    tests++;
    if (a.rd_data[31:0] !== 32'd45) begin
      fails++;
      $display("FAIL write_r21 got %0d want 45", a.rd_data[31:0]);
    end
    tests++;
    if (a.rd_data[63:32] !== 32'd0) begin
      fails++;
      $display("FAIL write_r5 got %0d want 0", a.rd_data[63:32]);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    a.wr_en   = 2'b10;
    a.wr_addr = {5'd23, 5'd0};
    a.wr_data = {32'd69, 32'd0};
    a.rd_addr = {5'd0, 5'd23};
    #1;
    tests++;
    if (a.rd_data[31:0] !== 32'd69) begin
      fails++;
      $display("FAIL byp_on got %0d want 69", a.rd_data[31:0]);
    end
    tests++;
    if (b.rd_data[31:0] !== 32'd0) begin
      fails++;
      $display("FAIL byp_off got %0d want 0", b.rd_data[31:0]);
    end
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (b.rd_data[31:0] !== 32'd69) begin
      fails++;
      $display("FAIL byp_after got %0d want 69", b.rd_data[31:0]);
    end
  endtask

  task automatic test_conflict();
    @(negedge clk);
    a.wr_en   = 2'b11;
    a.wr_addr = {5'd7, 5'd7};
    a.wr_data = {32'd22, 32'd11};
    a.rd_addr = {5'd0, 5'd7};
    #1;
    tests++;
    if (a.rd_data[31:0] !== 32'd22) begin
      fails++;
      $display("FAIL conf_byp got %0d want 22", a.rd_data[31:0]);
    end
    @(posedge clk);
    #1;
    tests++;
    if (a.wr_conflict !== 1'b1) begin
      fails++;
      $display("FAIL conf_flag got %0b want 1", a.wr_conflict);
    end
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (b.rd_data[31:0] !== 32'd22) begin
      fails++;
      $display("FAIL conf_r7 got %0d want 22", b.rd_data[31:0]);
    end
    @(posedge clk);
    #1;
    tests++;
    if (a.wr_conflict !== 1'b0) begin
      fails++;
      $display("FAIL conf_clear got %0b want 0", a.wr_conflict);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    a.resv_en   = 1'b1;
    a.resv_addr = 5'd9;
    a.rd_addr   = {5'd10, 5'd9};
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (a.rd_busy[0] !== 1'b1 || a.busy_cnt !== 6'd1) begin
      fails++;
      $display("FAIL sb_resv got busy=%0b cnt=%0d want 1 1",
               a.rd_busy[0], a.busy_cnt);
    end
    a.wr_en     = 2'b01;
    a.wr_addr   = {5'd0, 5'd9};
    a.wr_data   = {32'd0, 32'd5};
    a.resv_en   = 1'b1;
    a.resv_addr = 5'd9;
    #1;
    tests++;
    if (a.rd_busy[0] !== 1'b0 || b.rd_busy[0] !== 1'b1) begin
      fails++;
      $display("FAIL sb_mask got a=%0b b=%0b want 0 1",
               a.rd_busy[0], b.rd_busy[0]);
    end
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (a.rd_busy[0] !== 1'b1 || a.busy_cnt !== 6'd1 ||
        a.rd_data[31:0] !== 32'd5) begin
      fails++;
      $display("FAIL sb_setwins got busy=%0b cnt=%0d d=%0d want 1 1 5",
               a.rd_busy[0], a.busy_cnt, a.rd_data[31:0]);
    end
    a.resv_en   = 1'b1;
    a.resv_addr = 5'd9;
    @(negedge clk);
    a.resv_addr = 5'd10;
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (a.busy_cnt !== 6'd2 || a.rd_busy !== 2'b11) begin
      fails++;
      $display("FAIL sb_two got cnt=%0d busy=%0b want 2 11",
               a.busy_cnt, a.rd_busy);
    end
    a.wr_en   = 2'b11;
    a.wr_addr = {5'd10, 5'd9};
    a.wr_data = {32'd8, 32'd6};
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (a.rd_busy !== 2'b00 || a.busy_cnt !== 6'd0) begin
      fails++;
      $display("FAIL sb_clear got busy=%0b cnt=%0d want 00 0",
               a.rd_busy, a.busy_cnt);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    a.wr_en     = 2'b01;
    a.wr_addr   = {5'd0, 5'd0};
    a.wr_data   = {32'd0, 32'd99};
    a.resv_en   = 1'b1;
    a.resv_addr = 5'd0;
    a.rd_addr   = {5'd0, 5'd0};
    #1;
    tests++;
    if (a.rd_data[31:0] !== 32'd0) begin
      fails++;
      $display("FAIL zero_byp got %0d want 0", a.rd_data[31:0]);
    end
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (a.rd_data[31:0] !== 32'd0 || a.rd_busy[0] !== 1'b0 ||
        a.busy_cnt !== 6'd0) begin
      fails++;
      $display("FAIL zero_reg got d=%0d busy=%0b cnt=%0d want 0 0 0",
               a.rd_data[31:0], a.rd_busy[0], a.busy_cnt);
    end
    tests++;
    if (a.wr_conflict !== 1'b0) begin
      fails++;
      $display("FAIL zero_conf got %0b want 0", a.wr_conflict);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a.resv_en   = 1'b1;
    a.resv_addr = 5'd12;
    @(negedge clk);
    idle();
    a.wr_en   = 2'b01;
    a.wr_addr = {5'd0, 5'd21};
    a.wr_data = {32'd0, 32'd77};
    a.rd_addr = {5'd21, 5'd21};
    a.resv_en   = 1'b1;
    a.resv_addr = 5'd13;
    #1;
    tests++;
    if (a.rd_data[31:0] !== 32'd77 || a.busy_cnt !== 6'd1) begin
      fails++;
      $display("FAIL mid_pre got d=%0d cnt=%0d want 77 1",
               a.rd_data[31:0], a.busy_cnt);
    end
    #1 rst = 1'b0;
    #1;
    tests++;
    if (a.rd_data[31:0] !== 32'd0 || b.rd_data[63:32] !== 32'd0 ||
        a.busy_cnt !== 6'd0) begin
      fails++;
      $display("FAIL mid_rst got a=%0d b=%0d cnt=%0d want 0 0 0",
               a.rd_data[31:0], b.rd_data[63:32], a.busy_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    idle();
    #1;
    tests++;
    if (a.rd_data[31:0] !== 32'd0 || a.busy_cnt !== 6'd0) begin
      fails++;
      $display("FAIL mid_lost got d=%0d cnt=%0d want 0 0",
               a.rd_data[31:0], a.busy_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_bypass();
    test_conflict();
    test_scoreboard();
    test_zero_reg();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
